// File: rtl/cskipa_16b_arbiter.sv
// Round-robin front end sharing one external carry-skip adder between NREQ requesters.
// Define CSKIPA_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module cskipa_16b_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic [WIDTH-1:0]          add_in0,
    output logic [WIDTH-1:0]          add_in1,
    input  logic [WIDTH:0]            add_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH:0]            rsp_sum,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      busy
);

    localparam int unsigned IDW = $clog2(NREQ);

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [IDW-1:0]   r_id;
    logic [3:0]       r_cnt;
    logic             r_rsp_valid;
    logic [WIDTH:0]   r_rsp_sum;
    logic [IDW-1:0]   r_rsp_id;
`ifndef CSKIPA_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]   r_last;
`endif

    logic [IDW-1:0]   w_winner;
    logic [NREQ-1:0]  w_grant;
    logic             w_xfer;

    always_comb begin
        w_winner = '0;
`ifdef CSKIPA_ARB_FIXED_PRIO_EN
        // Descending scan so the lowest valid index is the final assignment.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) w_winner = IDW'(i);
        end
`else
        // Descending offset scan: the nearest valid requester after r_last wins.
        for (int i = NREQ; i >= 1; i--) begin
            if (req_valid[(int'(r_last) + i) % NREQ]) begin
                w_winner = IDW'((int'(r_last) + i) % NREQ);
            end
        end
`endif
    end

    always_comb begin
        w_grant = '0;
        if (rst_n && r_state == StIdle && |req_valid) w_grant[w_winner] = 1'b1;
        w_xfer = |w_grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_id    <= '0;
`ifndef CSKIPA_ARB_FIXED_PRIO_EN
            r_last      <= IDW'(NREQ - 1);
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_xfer) begin
                        r_op_a  <= req_a[w_winner*WIDTH +: WIDTH];
                        r_op_b  <= req_b[w_winner*WIDTH +: WIDTH];
                        r_id    <= w_winner;
                        r_cnt   <= 4'(SETTLE);
                        r_state <= StSettle;
`ifndef CSKIPA_ARB_FIXED_PRIO_EN
                        r_last  <= w_winner;
`endif
                    end
                end
                StSettle: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_rsp_sum   <= add_out;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign add_in0   = r_op_a;
    assign add_in1   = r_op_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_cskipa_16b_arbiter.sv
// Scoreboard bench for cskipa_16b_arbiter: a negedge monitor predicts grants, sums and timing
// from a plain arbitration model; a second instance with SETTLE=3 covers the longer window.
module tb_cskipa_16b_arbiter;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 16;
    localparam int SETTLE = 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      add_in0, add_in1;
    logic [WIDTH:0]        add_out;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [WIDTH:0]        rsp_sum;
    logic [1:0]            rsp_id;
    logic                  busy;

    logic [NREQ-1:0]       t3_req_valid = '0;
    logic [NREQ*WIDTH-1:0] t3_req_a = '0;
    logic [NREQ*WIDTH-1:0] t3_req_b = '0;
    logic [NREQ-1:0]       t3_req_ready;
    logic [WIDTH-1:0]      t3_add_in0, t3_add_in1;
    logic [WIDTH:0]        t3_add_out;
    logic                  t3_rsp_valid;
    logic                  t3_rsp_ready = 1'b0;
    logic [WIDTH:0]        t3_rsp_sum;
    logic [1:0]            t3_rsp_id;
    logic                  t3_busy;

    assign add_out    = {1'b0, add_in0} + {1'b0, add_in1};
    assign t3_add_out = {1'b0, t3_add_in0} + {1'b0, t3_add_in1};

    cskipa_16b_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .add_in0(add_in0), .add_in1(add_in1), .add_out(add_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
        .busy(busy)
    );

    cskipa_16b_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(t3_req_valid), .req_a(t3_req_a), .req_b(t3_req_b),
        .req_ready(t3_req_ready), .add_in0(t3_add_in0), .add_in1(t3_add_in1),
        .add_out(t3_add_out), .rsp_valid(t3_rsp_valid), .rsp_ready(t3_rsp_ready),
        .rsp_sum(t3_rsp_sum), .rsp_id(t3_rsp_id), .busy(t3_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   sum;
        int               id;
        int               t_acc;
    } exp_t;

    exp_t             sbq[$];
    int               grant_log[$];
    int               acc_cyc[$];
    int               vectors = 0;
    int               miscompares = 0;
    int               cyc = 0;
    int               m_last = NREQ - 1;
    bit               m_busy = 1'b0;
    logic [WIDTH-1:0] m_a = '0;
    logic [WIDTH-1:0] m_b = '0;
    logic [NREQ-1:0]  granted_flag = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Reference arbitration: who should win given the current valids and last winner.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
`ifdef CSKIPA_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`else
        for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    exp_t        mon_e;
    int          mon_w;
    logic [31:0] mon_ready;
    bit          mon_rv;

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            m_busy = 1'b0;
            m_last = NREQ - 1;
            m_a = '0;
            m_b = '0;
            granted_flag = '0;
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_add_in0", 32'(add_in0), 0);
            check("rst_add_in1", 32'(add_in1), 0);
            check("rst_rsp_sum", 32'(rsp_sum), 0);
            check("rst_rsp_id", 32'(rsp_id), 0);
        end else if (m_busy && sbq.size() > 0) begin
            mon_e  = sbq[0];
            mon_rv = (cyc - mon_e.t_acc) >= SETTLE + 1;
            check("busy_high", 32'(busy), 1);
            check("ready_while_busy", 32'(req_ready), 0);
            check("add_in0_held", 32'(add_in0), 32'(mon_e.a));
            check("add_in1_held", 32'(add_in1), 32'(mon_e.b));
            check("rsp_valid_timing", 32'(rsp_valid), 32'(mon_rv));
            if (mon_rv) begin
                check("rsp_sum", 32'(rsp_sum), 32'(mon_e.sum));
                check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                if (rsp_ready) begin
                    void'(sbq.pop_front());
                    m_busy = 1'b0;
                end
            end
        end else begin
            check("busy_idle", 32'(busy), 0);
            check("rsp_valid_idle", 32'(rsp_valid), 0);
            check("add_in0_idle", 32'(add_in0), 32'(m_a));
            check("add_in1_idle", 32'(add_in1), 32'(m_b));
            mon_w     = rr_pick(req_valid, m_last);
            mon_ready = (mon_w < 0) ? 32'd0 : (32'd1 << mon_w);
            check("grant", 32'(req_ready), mon_ready);
            if (mon_w >= 0) begin
                mon_e.a     = req_a[mon_w*WIDTH +: WIDTH];
                mon_e.b     = req_b[mon_w*WIDTH +: WIDTH];
                mon_e.sum   = 17'(mon_e.a) + 17'(mon_e.b);
                mon_e.id    = mon_w;
                mon_e.t_acc = cyc;
                sbq.push_back(mon_e);
                m_busy = 1'b1;
                m_last = mon_w;
                m_a    = mon_e.a;
                m_b    = mon_e.b;
                granted_flag[mon_w] = 1'b1;
                grant_log.push_back(mon_w);
                acc_cyc.push_back(cyc);
            end
        end
    end

    // Advance one cycle; a granted requester drops its request after the accepting edge.
    task automatic step();
        @(posedge clk);
        #2;
        for (int k = 0; k < NREQ; k++) begin
            if (granted_flag[k]) begin
                req_valid[k]    = 1'b0;
                granted_flag[k] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_valid[k]           = 1'b1;
        req_a[k*WIDTH +: WIDTH] = a;
        req_b[k*WIDTH +: WIDTH] = b;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        rsp_ready = 1'b1;
        while ((m_busy || req_valid != '0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check("drain_timeout", {31'd0, m_busy}, 0);
    endtask

    task automatic run_continuous(input logic [NREQ-1:0] mask, input int nops, input int budget);
        int n = 0;
        grant_log.delete();
        acc_cyc.delete();
        for (int k = 0; k < NREQ; k++) if (mask[k]) set_req(k, 16'(16'h1000 * k), 16'(k));
        while (grant_log.size() < nops && n < budget) begin
            step();
            n++;
            if (grant_log.size() < nops) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (mask[k] && !req_valid[k]) set_req(k, 16'(16'h1000 * k), 16'(k));
                end
            end
        end
        if (n >= budget) check("continuous_timeout", 32'(grant_log.size()), 32'(nops));
        req_valid = '0;
    endtask

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();

`ifdef CSKIPA_ARB_FIXED_PRIO_EN
        rsp_ready = 1'b1;
        run_continuous(4'b0101, 10, 200);
        foreach (grant_log[i]) check("fixed_prio_grant", 32'(grant_log[i]), 0);
        drain(50);
`else
        // Contention: all four valid, expect 0,1,2,3,0 at SETTLE+2 spacing.
        rsp_ready = 1'b1;
        run_continuous(4'b1111, 5, 200);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            check("contention_order", 32'(grant_log[i]), 32'(i % NREQ));
            if (i > 0) check("contention_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), SETTLE + 2);
        end
        drain(50);
`endif

        // Single request with carry out.
        set_req(0, 16'hFFFF, 16'h0001);
        drain(50);

        // Backpressure: hold rsp_ready low for several cycles inside RESP.
        rsp_ready = 1'b0;
        set_req(2, 16'($urandom), 16'($urandom));
        n = 0;
        while (!(m_busy && (cyc - sbq[0].t_acc) >= SETTLE + 1) && n < 20) begin
            step();
            n++;
        end
        set_req(1, 16'h1234, 16'h4321);
        repeat (5) step();
        drain(50);

        // Reset while req1 is in SETTLE: the in-flight result must never appear.
        rsp_ready = 1'b1;
        set_req(1, 16'hABCD, 16'h1111);
        n = 0;
        while (req_valid[1] && n < 20) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        step();
        grant_log.delete();
        set_req(0, 16'h0005, 16'h0006);
        set_req(1, 16'h0007, 16'h0008);
        rst_n = 1'b1;
        drain(50);
        if (grant_log.size() > 0) check("post_reset_first_grant", 32'(grant_log[0]), 0);
        else check("post_reset_grants", 32'(grant_log.size()), 2);

        // Randomized traffic with random backpressure and occasional withdrawn requests.
        for (int c = 0; c < 400; c++) begin
            step();
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] && $urandom_range(0, 2) == 0) set_req(k, 16'($urandom), 16'($urandom));
                else if (req_valid[k] && $urandom_range(0, 19) == 0) req_valid[k] = 1'b0;
            end
        end
        req_valid = '0;
        drain(50);

        // SETTLE=3 instance: accept, hold operands three cycles, then sample.
        t3_rsp_ready = 1'b1;
        t3_req_valid[0] = 1'b1;
        t3_req_a[WIDTH-1:0] = 16'h8000;
        t3_req_b[WIDTH-1:0] = 16'h8000;
        @(negedge clk);
        check("s3_grant", 32'(t3_req_ready), 1);
        step();
        t3_req_valid = '0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("s3_add_in0", 32'(t3_add_in0), 32'h8000);
            check("s3_add_in1", 32'(t3_add_in1), 32'h8000);
            check("s3_busy", 32'(t3_busy), 1);
            check("s3_rsp_valid", 32'(t3_rsp_valid), (i == 4) ? 1 : 0);
        end
        check("s3_rsp_sum", 32'(t3_rsp_sum), 32'h10000);
        check("s3_rsp_id", 32'(t3_rsp_id), 0);
        @(negedge clk);
        check("s3_idle_after", 32'({t3_busy, t3_rsp_valid}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
